// File: rtl/seq_detector_if.sv
// Serial detector bus: sample stream, control strobes and the detector's status.
interface seq_detector_if #(
    parameter int PATTERN_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8
);
    logic                     y_in;
    logic                     valid_in;
    logic                     overlap;
    logic [PATTERN_WIDTH-1:0] pattern_in;
    logic                     pattern_load;
    logic                     clear_count;
    logic                     x_out;
    logic [COUNT_WIDTH-1:0]   match_count;
    logic                     armed;

    // Source side: drives the stream and controls, observes the results.
    modport master (
        output y_in, valid_in, overlap, pattern_in, pattern_load, clear_count,
        input  x_out, match_count, armed
    );

    // Detector side.
    modport slave (
        input  y_in, valid_in, overlap, pattern_in, pattern_load, clear_count,
        output x_out, match_count, armed
    );
endinterface

// File: rtl/seq_detector.sv
// Loadable serial-pattern detector with overlap / non-overlap matching,
// saturating match counter and an armed flag. All outputs registered.
module seq_detector #(
    parameter int PATTERN_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8,
    parameter logic [PATTERN_WIDTH-1:0] RESET_PATTERN = PATTERN_WIDTH'(4'b1011)
) (
    input logic           clock,
    input logic           reset,
    seq_detector_if.slave bus
);
    localparam int FW = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FW-1:0]          FULL    = FW'(PATTERN_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {FILL, SEARCH} state_t;

    state_t                   state, state_nxt;
    logic [PATTERN_WIDTH-1:0] pat, pat_nxt;
    // Only the younger PATTERN_WIDTH-1 bits of history can reach the next
    // compare; the oldest bit falls out on every shift, so it is not kept.
    logic [PATTERN_WIDTH-2:0] shreg, shreg_nxt;
    logic [FW-1:0]            fill, fill_nxt, fill_inc;
    logic [PATTERN_WIDTH-1:0] shifted;
    logic                     accept, match;
    logic                     x_q, x_nxt;
    logic [COUNT_WIDTH-1:0]   cnt, cnt_nxt;

    // State register: reset wins over everything, including a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
            pat   <= RESET_PATTERN;
            shreg <= '0;
            fill  <= '0;
            x_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pat   <= pat_nxt;
            shreg <= shreg_nxt;
            fill  <= fill_nxt;
            x_q   <= x_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: accept/shift, fill tracking, match detection and counter.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        shreg_nxt = shreg;
        fill_nxt  = fill;
        x_nxt     = 1'b0;
        cnt_nxt   = cnt;

        // A load steals the cycle: any sample alongside it is dropped.
        accept   = bus.valid_in && !bus.pattern_load;
        shifted  = {shreg, bus.y_in};
        fill_inc = (fill == FULL) ? fill : fill + FW'(1);
        match    = accept && (fill_inc == FULL) && (shifted == pat);

        if (bus.pattern_load) begin
            pat_nxt   = bus.pattern_in;
            fill_nxt  = '0;
            state_nxt = FILL;
        end else if (accept) begin
            shreg_nxt = shifted[PATTERN_WIDTH-2:0];
            fill_nxt  = fill_inc;
            state_nxt = (fill_inc == FULL) ? SEARCH : FILL;
            if (match) begin
                x_nxt = 1'b1;
                // Non-overlap: the matched bits may not be reused.
                if (!bus.overlap) begin
                    fill_nxt  = '0;
                    state_nxt = FILL;
                end
            end
        end

        // A clear coinciding with a match leaves that match counted.
        if (bus.clear_count) begin
            cnt_nxt = match ? COUNT_WIDTH'(1) : '0;
        end else if (match && cnt != CNT_MAX) begin
            cnt_nxt = cnt + COUNT_WIDTH'(1);
        end
    end

    assign bus.x_out       = x_q;
    assign bus.match_count = cnt;
    assign bus.armed       = (state == SEARCH);
endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench: two detectors (8-bit and 2-bit counters) share one
// stimulus stream; a behavioural model predicts each cycle's outputs.
module tb_seq_detector;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_detector_if #(.PATTERN_WIDTH(4), .COUNT_WIDTH(8)) bus8 ();
    seq_detector_if #(.PATTERN_WIDTH(4), .COUNT_WIDTH(2)) bus2 ();

    seq_detector #(.PATTERN_WIDTH(4), .COUNT_WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .bus(bus8.slave)
    );
    seq_detector #(.PATTERN_WIDTH(4), .COUNT_WIDTH(2)) dut2 (
        .clock(clk), .reset(rst), .bus(bus2.slave)
    );

    typedef struct {
        logic       x;
        logic       armed;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sbq[$];

    int nvec = 0;
    int nerr = 0;
    int stepn = 0;

    // Reference model state (history kept as a plain bit list length)
    logic [3:0] m_pat;
    logic [3:0] m_hist;
    int         m_len;
    logic       m_x;
    logic [7:0] m_c8;
    logic [1:0] m_c2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0h, expected %0h", tag, stepn, got, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic y, input logic ov,
                        input logic ld, input logic [3:0] pin, input logic clr);
        exp_t e;
        logic m;
        rst = r;
        bus8.y_in = y;  bus8.valid_in = v;  bus8.overlap = ov;
        bus8.pattern_in = pin;  bus8.pattern_load = ld;  bus8.clear_count = clr;
        bus2.y_in = y;  bus2.valid_in = v;  bus2.overlap = ov;
        bus2.pattern_in = pin;  bus2.pattern_load = ld;  bus2.clear_count = clr;

        m = 1'b0;
        if (r) begin
            m_pat = 4'b1011; m_hist = 4'b0; m_len = 0; m_c8 = 0; m_c2 = 0;
        end else begin
            if (ld) begin
                m_pat = pin;
                m_len = 0;
            end else if (v) begin
                m_hist = {m_hist[2:0], y};
                if (m_len < 4) m_len++;
                m = (m_len == 4) && (m_hist == m_pat);
                if (m && !ov) m_len = 0;
            end
            if (clr) begin
                m_c8 = m ? 8'd1 : 8'd0;
                m_c2 = m ? 2'd1 : 2'd0;
            end else if (m) begin
                if (m_c8 != 8'hFF) m_c8++;
                if (m_c2 != 2'h3) m_c2++;
            end
        end
        m_x = m;
        e.x = m_x; e.armed = (m_len == 4); e.c8 = m_c8; e.c2 = m_c2;
        sbq.push_back(e);

        @(posedge clk);
        #1;
        stepn++;
        e = sbq.pop_front();
        chk("x_out",   32'(bus8.x_out),       32'(e.x));
        chk("armed",   32'(bus8.armed),       32'(e.armed));
        chk("count8",  32'(bus8.match_count), 32'(e.c8));
        chk("x_out2",  32'(bus2.x_out),       32'(e.x));
        chk("count2",  32'(bus2.match_count), 32'(e.c2));
    endtask

    // Accepted bit with no controls.
    task automatic bit_in(input logic y, input logic ov);
        step(1'b0, 1'b1, y, ov, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom));
    endtask

    logic [6:0] strm;

    initial begin
        m_pat = 4'b1011; m_hist = 0; m_len = 0; m_x = 0; m_c8 = 0; m_c2 = 0;

        // Reset with random inputs
        do_reset(2);

        // Overlap: 1,0,1,1,0,1,1 -> pulses on 4th and 7th
        strm = 7'b1011011;
        for (int i = 6; i >= 0; i--) bit_in(strm[i], 1'b1);
        idle(1);

        // Non-overlap: same stream -> one pulse, disarmed after
        do_reset(1);
        for (int i = 6; i >= 0; i--) bit_in(strm[i], 1'b0);
        idle(1);

        // Stalls of 1-3 cycles between bits
        do_reset(1);
        for (int i = 3; i >= 0; i--) begin
            bit_in(strm[i+3], 1'b1);
            idle(1 + (i % 3));
        end

        // Saturation: pattern 1111, nine 1s, then a 10th with clear
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 9; i++) bit_in(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        idle(1);

        // Load mid-stream: load-cycle bit is dropped
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        idle(1);

        // Reset mid-stream: partial 1,0,1 must not combine with later bits
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        do_reset(1);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        idle(1);

        // Random soak with occasional loads, clears and resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 3) | 4'b1000),
                 ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial-pattern detector, the next generation of the single-input Moore state machines used in this project. Watches a one-bit serial stream `y_in` that is qualified by `valid_in`. Pulses `x_out` when the last PATTERN_WIDTH accepted bits equal a loadable pattern. Adds overlap or non-overlap matching, a saturating match counter, and an `armed` status flag. Sits between a serial source and downstream control logic in the same clock domain.

## Interface
- PATTERN_WIDTH, 4: pattern length in bits, at least 2.
- COUNT_WIDTH, 8: width of `match_count`, at least 1.
- RESET_PATTERN, 4'b1011 (zero-extended or truncated to PATTERN_WIDTH): pattern value after reset.

Ports:
- clock  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high. Clears all state on the next rising edge.
- y_in  in  1  Serial data bit.
- valid_in  in  1  When high, `y_in` is accepted this cycle.
- overlap  in  1  1 selects overlap mode: detection history is kept after a match. 0 selects non-overlap mode: history is cleared after a match.
- pattern_in  in  PATTERN_WIDTH  New pattern value. The MSB is the earliest bit.
- pattern_load  in  1  Latches `pattern_in` and clears the detection history.
- clear_count  in  1  Clears `match_count`.
- x_out  out  1  One-cycle match pulse, registered.
- match_count  out  COUNT_WIDTH  Saturating count of matches.
- armed  out  1  High when PATTERN_WIDTH bits of history are held (state SEARCH).

## Operation
- Internal registers:
  - `pat`: PATTERN_WIDTH bits.
  - `shreg`: PATTERN_WIDTH bits.
  - `fill`: 0..PATTERN_WIDTH.
  - FSM with states FILL and SEARCH. `armed` = (state == SEARCH).
- Accepted sample (`valid_in`=1 and `pattern_load`=0):
  - `shreg_next` = {shreg[PATTERN_WIDTH-2:0], y_in}.
  - FILL: `fill` increments. Move to SEARCH when `fill` reaches PATTERN_WIDTH.
- Match: an accepted sample where `fill_next` == PATTERN_WIDTH and `shreg_next` == `pat`. This includes the sample that completes the fill.
- On a match:
  - `x_out` <= 1.
  - `match_count` increments, holding at all-ones.
  - overlap=1: stay in SEARCH, `fill` stays at PATTERN_WIDTH.
  - overlap=0: go to FILL with `fill` = 0. `shreg` contents become don't-care.
- No match, or no accepted sample: `x_out` <= 0.
- `pattern_load`=1:
  - `pat` <= `pattern_in`; go to FILL with `fill` = 0.
  - A sample presented in the same cycle is discarded, and no match is possible.
  - `match_count` is unaffected.
- `clear_count`=1:
  - `match_count` <= 0.
  - If a match occurs in the same cycle, `match_count` <= 1 instead.
- `overlap` is sampled on every cycle. Changing it mid-stream affects only the next match.
- Reset values:
  - `x_out`=0, `match_count`=0, `armed`=0.
  - `pat`=RESET_PATTERN, `shreg`=0, `fill`=0, state FILL.
- Reset has priority over every other input.
- Reset asserted mid-stream discards the partial history. Detection restarts with the first accepted sample after reset deasserts.

## Timing
- Latency: `x_out` goes high on the clock edge that accepts the final pattern bit, so it is visible in the following cycle for exactly one cycle.
- `match_count` updates on the same edge as `x_out`.
- Back-to-back overlap matches can produce `x_out` high on consecutive cycles. Example: pattern 1111 with a continuous stream of 1s.
- Cycles with `valid_in`=0 change nothing except forcing `x_out` to 0.
- `armed` updates on the same edge as `fill`. It drops on the match edge in non-overlap mode and on the `pattern_load` edge.
- No combinational path from any input to any output.

## Test plan
Defaults: PATTERN_WIDTH=4, RESET_PATTERN=1011, `valid_in`=1 unless noted.
- **Reset:** hold `reset` 2 cycles with random inputs -> `x_out`=0, `match_count`=0, `armed`=0 on every cycle after the first edge.
- **Overlap:** overlap=1, stream 1,0,1,1,0,1,1 -> `x_out` pulses after the 4th and 7th accepted bits; `match_count`=2; `armed`=1 from the 4th bit onward.
- **Non-overlap:** overlap=0, same stream -> single pulse after the 4th bit; `match_count`=1; `armed`=0 after the match edge.
- **Stalls:** stream 1,0,1,1 with `valid_in`=0 gaps of 1-3 cycles between bits -> one pulse, on the cycle after the 4th valid bit only.
- **Saturation and clear:**
  - COUNT_WIDTH=2, overlap=1, pattern 1111, nine 1s -> `x_out` high on 6 consecutive cycles; `match_count` holds at 3.
  - `clear_count` on the edge of a 7th match -> `match_count`=1.
- **Load and reset mid-stream:**
  - Feed 1,0,1, then pulse `pattern_load` with 0110 while `y_in`=1, then feed 0,1,1,0 -> the load-cycle bit is ignored; one pulse after the final 0.
  - Repeat with `reset` asserted after 1,0,1 -> no pulse until 4 fresh matching bits arrive.
